// File: rtl/mdu_iter.sv
// Multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU run for a fixed number of cycles with busy raised so the
// pipeline can stall; MTHI/MTLO write HI/LO in a single cycle when idle.
module mdu_iter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2         = 2 * WIDTH;
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;

    logic [W2-1:0]    prod_c;
    logic             neg_a_c;
    logic             neg_b_c;
    logic [WIDTH-1:0] abs_a_c;
    logic [WIDTH-1:0] abs_b_c;
    logic [WIDTH-1:0] den_c;
    logic [WIDTH-1:0] uq_c;
    logic [WIDTH-1:0] ur_c;
    logic [WIDTH-1:0] res_hi_c;
    logic [WIDTH-1:0] res_lo_c;

    // Result of the captured operation, consumed only on the completion edge.
    // Signed division works on magnitudes; the most-negative / -1 case falls out
    // naturally (magnitude 2^(W-1) wraps back to the most-negative pattern, rem 0).
    always_comb begin
        prod_c   = '0;
        neg_a_c  = 1'b0;
        neg_b_c  = 1'b0;
        abs_a_c  = a_q;
        abs_b_c  = b_q;
        den_c    = b_q;
        uq_c     = '0;
        ur_c     = '0;
        res_hi_c = '0;
        res_lo_c = '0;

        if (op_q[0]) begin
            prod_c = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        end else begin
            prod_c = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        end

        neg_a_c = ~op_q[0] & a_q[WIDTH-1];
        neg_b_c = ~op_q[0] & b_q[WIDTH-1];
        abs_a_c = neg_a_c ? (-a_q) : a_q;
        abs_b_c = neg_b_c ? (-b_q) : b_q;
        den_c   = (b_q == '0) ? WIDTH'(1) : abs_b_c;
        uq_c    = abs_a_c / den_c;
        ur_c    = abs_a_c % den_c;

        if (op_q[1]) begin
            if (b_q == '0) begin
                res_lo_c = '1;
                res_hi_c = a_q;
            end else begin
                res_lo_c = (neg_a_c ^ neg_b_c) ? (-uq_c) : uq_c;
                res_hi_c = neg_a_c ? (-ur_c) : ur_c;
            end
        end else begin
            res_hi_c = prod_c[W2-1:WIDTH];
            res_lo_c = prod_c[WIDTH-1:0];
        end
    end

    // Control FSM, operand capture and architectural HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            a_q   <= A;
                            b_q   <= B;
                            op_q  <= op[1:0];
                            cnt   <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            state <= BUSY;
                            busy  <= 1'b1;
                        end else if (op == 3'b100) begin
                            hi <= A;
                        end else if (op == 3'b101) begin
                            lo <= A;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        hi    <= res_hi_c;
                        lo    <= res_lo_c;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed test-plan cases plus randomized
// traffic, all compared every cycle against a behavioural model.
module tb_mdu_iter;

    localparam int unsigned W  = 32;
    localparam int          NM = 5;
    localparam int          ND = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b110;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;

    mdu_iter #(.WIDTH(W), .MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Architectural result of one op, straight from the arithmetic definitions.
    function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] rh, output logic [W-1:0] rl);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = $signed(a);
        sb = $signed(b);
        ua = 64'(a);
        ub = 64'(b);
        rh = '0;
        rl = '0;
        case (o)
            3'd0: begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
            3'd1: begin p = ua * ub;      rh = p[63:32]; rl = p[31:0]; end
            3'd2: begin
                if (b == 0) begin rl = '1; rh = a; end
                else begin
                    q = sa / sb; r = sa % sb;
                    p = 64'(q); rl = p[31:0];
                    p = 64'(r); rh = p[31:0];
                end
            end
            default: begin
                if (b == 0) begin rl = '1; rh = a; end
                else begin
                    p = ua / ub; rl = p[31:0];
                    p = ua % ub; rh = p[31:0];
                end
            end
        endcase
    endfunction

    // Behavioural model: a pending result that lands at a known completion cycle.
    logic         m_busy = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    longint       cyc = 0, done_cyc = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 1'b0; m_hi = '0; m_lo = '0;
        end else begin
            cyc = cyc + 1;
            if (m_busy) begin
                if (cyc == done_cyc) begin
                    m_busy = 1'b0; m_hi = p_hi; m_lo = p_lo;
                end
            end else if (start) begin
                if (op < 3'd4) begin
                    ref_op(op, A, B, p_hi, p_lo);
                    done_cyc = cyc + ((op >= 3'd2) ? ND : NM);
                    m_busy   = 1'b1;
                end else if (op == 3'd4) begin
                    m_hi = A;
                end else if (op == 3'd5) begin
                    m_lo = A;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        total++;
        if (busy !== m_busy || hi !== m_hi || lo !== m_lo) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t busy=%b/%b hi=%h/%h lo=%h/%h", $time,
                     busy, m_busy, hi, m_hi, lo, m_lo);
        end
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic pin(input string name, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el);
        logic [W-1:0] rh, rl;
        ref_op(o, a, b, rh, rl);
        check({name, "_model_hi"}, rh, eh);
        check({name, "_model_lo"}, rl, el);
    endtask

    // Issue one mult/div, keep the line busy (noise) or wiggle operands while
    // busy, then check busy length and final HI/LO against literals.
    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise, input int exp_n, input logic [W-1:0] eh, input logic [W-1:0] el);
        int n;
        @(posedge clk); #2;
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #2;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            n++;
            if (noise) begin
                start = 1'b1;
                if (i % 2 == 0) begin op = 3'b100; A = 32'h1234; B = $urandom; end
                else begin op = 3'b011; A = $urandom; B = $urandom; end
            end else begin
                start = 1'b0; op = 3'b110; A = $urandom; B = $urandom;
            end
            @(posedge clk); #2;
        end
        start = 1'b0; op = 3'b110;
        check({name, "_busy_cycles"}, W'(n), W'(exp_n));
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
    endtask

    function automatic logic [W-1:0] pick_a();
        case ($urandom % 8)
            0: return 32'h8000_0000;
            1: return W'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [W-1:0] pick_b();
        case ($urandom % 8)
            0: return '0;
            1: return '1;
            2: return W'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1;
        check("reset_busy", W'(busy), '0);
        check("reset_hi", hi, '0);
        check("reset_lo", lo, '0);
        #11 reset = 1'b1;

        pin("mult",   3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        pin("multu",  3'd1, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE);
        pin("div",    3'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        pin("divu",   3'd3, 32'h7, 32'h2, 32'h1, 32'h3);
        pin("div0",   3'd3, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF);
        pin("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        run_op("mult",   3'd0, 32'hFFFF_FFFF, 32'h2, 1'b0, NM, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu",  3'd1, 32'hFFFF_FFFF, 32'h2, 1'b0, NM, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div",    3'd2, 32'hFFFF_FFF9, 32'h2, 1'b0, ND, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",   3'd3, 32'h7, 32'h2, 1'b0, ND, 32'h1, 32'h3);
        run_op("div0",   3'd3, 32'h5, 32'h0, 1'b0, ND, 32'h5, 32'hFFFF_FFFF);
        run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, ND, 32'h0, 32'h8000_0000);
        run_op("noisy",  3'd0, 32'hFFFF_FFFF, 32'h2, 1'b1, NM, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // MTHI once idle again.
        start = 1'b1; op = 3'b100; A = 32'h1234;
        @(posedge clk); #2;
        start = 1'b0; op = 3'b110;
        check("mthi_hi", hi, 32'h1234);
        check("mthi_lo", lo, 32'hFFFF_FFFE);

        // Asynchronous reset in the middle of a DIV.
        start = 1'b1; op = 3'd2; A = 32'h100; B = 32'h3;
        @(posedge clk); #2;
        start = 1'b0; op = 3'b110;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_busy", W'(busy), '0);
        check("midrst_hi", hi, '0);
        check("midrst_lo", lo, '0);
        #6 reset = 1'b1;
        run_op("after_rst", 3'd1, 32'h3, 32'h4, 1'b0, NM, 32'h0, 32'hC);

        // Random traffic, including requests while busy and boundary operands.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #2;
            start = ($urandom % 3) != 0;
            op    = ($urandom % 4 == 0) ? 3'(4 + $urandom % 4) : 3'($urandom % 4);
            A     = pick_a();
            B     = pick_b();
        end
        start = 1'b0; op = 3'b110;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if (!busy && !m_busy) break;
        end
        check("drain_busy", W'(busy), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
